meas_wr_arbiter: RTL

//   Shares the single 64-bit regfile write port among the N_CH measure channels.

---
 rtl/meas_wr_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/meas_wr_arbiter.sv
// Round-robin arbiter sharing one regfile write port among N_CH measure channels.
// Each channel holds one pending result; overflows are flagged and counted.
module meas_wr_arbiter #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 64,
    parameter int CH_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_CH-1:0]          raw_wr_en_i,
    input  logic [N_CH*DATA_W-1:0]   raw_wr_data_i,
    input  logic                     ovf_clr_i,
    output logic                     reg_wr_en_o,
    output logic [DATA_W-1:0]        reg_wr_data_o,
    output logic [CH_W-1:0]          reg_wr_ch_o,
    output logic [N_CH-1:0]          ovf_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    function automatic logic [CH_W:0] popcount(input logic [N_CH-1:0] v);
        logic [CH_W:0] n;
        n = '0;
        for (int i = 0; i < N_CH; i++) begin
            n = n + (CH_W+1)'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [CH_W:0]    b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [N_CH-1:0]   pend_p0;
    logic [DATA_W-1:0] hold_p0 [N_CH];
    logic [CH_W-1:0]   rr_ptr;

    logic              gnt_vld;
    logic [N_CH-1:0]   gnt_oh;
    logic [CH_W-1:0]   gnt_ch;
    logic [DATA_W-1:0] gnt_data;

    logic [N_CH-1:0]   cap;
    logic [N_CH-1:0]   drop;
    logic [N_CH-1:0]   pend_nxt;
    logic [N_CH-1:0]   ovf_base;
    logic [CNT_W-1:0]  cnt_base;

    // Grant search: first pending channel after the last granted one.
    always_comb begin
        int idx;
        gnt_vld  = 1'b0;
        gnt_oh   = '0;
        gnt_ch   = '0;
        gnt_data = '0;
        idx      = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!gnt_vld && pend_p0[idx]) begin
                gnt_vld     = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_ch      = CH_W'(idx);
                gnt_data    = hold_p0[idx];
            end
        end
    end

    // A channel granted this cycle frees its slot, so a same-cycle strobe is captured.
    assign cap      = raw_wr_en_i & (~pend_p0 | gnt_oh);
    assign drop     = raw_wr_en_i & pend_p0 & ~gnt_oh;
    assign pend_nxt = (pend_p0 & ~gnt_oh) | cap;
    assign ovf_base = ovf_clr_i ? '0 : ovf_o;
    assign cnt_base = ovf_clr_i ? '0 : drop_cnt_o;

    // Capture stage: holding buffers and pending flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_p0 <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hold_p0[i] <= '0;
            end
        end else begin
            pend_p0 <= pend_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (cap[i]) begin
                    hold_p0[i] <= raw_wr_data_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Write stage: registered regfile port, round-robin pointer, overflow status.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr        <= CH_W'(N_CH - 1);
            reg_wr_en_o   <= 1'b0;
            reg_wr_data_o <= '0;
            reg_wr_ch_o   <= '0;
            ovf_o         <= '0;
            drop_cnt_o    <= '0;
        end else begin
            reg_wr_en_o <= gnt_vld;
            if (gnt_vld) begin
                reg_wr_data_o <= gnt_data;
                reg_wr_ch_o   <= gnt_ch;
                rr_ptr        <= gnt_ch;
            end
            ovf_o      <= ovf_base | drop;
            drop_cnt_o <= sat_add(cnt_base, popcount(drop));
        end
    end

endmodule
